// File: rtl/activation_pipe.sv
// Two-stage activation pipeline (ReLU / leaky ReLU / saturating identity / clip) with valid/ready.
// Define ACTIVATION_SATCNT_EN to add the sticky 16-bit sat_count output.
module activation_pipe #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FRAC_BITS  = 11,
    parameter int unsigned IN_W       = 2*DATA_W-FRAC_BITS,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat
`ifdef ACTIVATION_SATCNT_EN
    ,
    output logic [15:0]       sat_count
`endif
);

    localparam logic [1:0] MODE_RELU  = 2'd0;
    localparam logic [1:0] MODE_LEAKY = 2'd1;
    localparam logic [1:0] MODE_IDENT = 2'd2;
    localparam logic [1:0] MODE_CLIP  = 2'd3;

    localparam int MAXP_I = (2**(DATA_W-1)) - 1;
    localparam int MINN_I = -(2**(DATA_W-1));
    localparam int ONE_I  = 2**FRAC_BITS;

    // Window limits at full accumulator width so overflow checks see every bit
    localparam logic signed [IN_W-1:0] MAXP_X = IN_W'(MAXP_I);
    localparam logic signed [IN_W-1:0] MINN_X = IN_W'(MINN_I);
    localparam logic signed [IN_W-1:0] ONE_X  = IN_W'(ONE_I);

    localparam logic [DATA_W-1:0] MAXP_D = DATA_W'(MAXP_I);
    localparam logic [DATA_W-1:0] MINN_D = DATA_W'(MINN_I);
    localparam logic [DATA_W-1:0] ONE_D  = DATA_W'(ONE_I);

    logic                    s1_valid_q;
    logic signed [IN_W-1:0]  s1_data_q;
    logic [1:0]              s1_mode_q;
    logic                    s1_sign_q;
    logic signed [IN_W-1:0]  s1_leak_q;
    logic                    s2_valid_q;

    logic                    s2_load;
    logic signed [IN_W-1:0]  in_leak;
    logic [DATA_W-1:0]       act_data;
    logic                    act_sat;
    logic                    gt_maxp;
    logic                    lt_minn;
    logic                    gt_one;
    logic                    leak_lt_minn;

    assign s2_load   = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_load;
    assign out_valid = s2_valid_q;
    assign in_leak   = $signed(in_data) >>> LEAK_SHIFT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= '0;
            s1_sign_q  <= 1'b0;
            s1_leak_q  <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q <= in_data;
                s1_mode_q <= in_mode;
                s1_sign_q <= in_data[IN_W-1];
                s1_leak_q <= in_leak;
            end
        end
    end

    assign gt_maxp      = s1_data_q > MAXP_X;
    assign lt_minn      = s1_data_q < MINN_X;
    assign gt_one       = s1_data_q > ONE_X;
    assign leak_lt_minn = s1_leak_q < MINN_X;

    always_comb begin
        act_data = s1_data_q[DATA_W-1:0];
        act_sat  = 1'b0;
        case (s1_mode_q)
            MODE_RELU: begin
                if (s1_sign_q) begin
                    act_data = '0;
                end else if (gt_maxp) begin
                    act_data = MAXP_D;
                    act_sat  = 1'b1;
                end
            end
            MODE_LEAKY: begin
                if (!s1_sign_q) begin
                    if (gt_maxp) begin
                        act_data = MAXP_D;
                        act_sat  = 1'b1;
                    end
                end else if (leak_lt_minn) begin
                    act_data = MINN_D;
                    act_sat  = 1'b1;
                end else begin
                    act_data = s1_leak_q[DATA_W-1:0];
                end
            end
            MODE_IDENT: begin
                if (gt_maxp) begin
                    act_data = MAXP_D;
                    act_sat  = 1'b1;
                end else if (lt_minn) begin
                    act_data = MINN_D;
                    act_sat  = 1'b1;
                end
            end
            MODE_CLIP: begin
                if (s1_sign_q) begin
                    act_data = '0;
                    act_sat  = 1'b1;
                end else if (gt_one) begin
                    act_data = ONE_D;
                    act_sat  = 1'b1;
                end
            end
            default: begin
                act_data = '0;
                act_sat  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            out_data   <= '0;
            out_sat    <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data <= act_data;
                out_sat  <= act_sat;
            end
        end
    end

`ifdef ACTIVATION_SATCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (s2_valid_q && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_activation_pipe.sv
// Directed self-checking bench for activation_pipe: modes, boundaries, backpressure, reset.
// Exercises sat_count as well when ACTIVATION_SATCNT_EN is defined.
module tb_activation_pipe;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned IN_W   = 21;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IN_W-1:0]   in_data = '0;
    logic [1:0]        in_mode = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_sat;
`ifdef ACTIVATION_SATCNT_EN
    logic [15:0]       sat_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    activation_pipe #(
        .DATA_W    (16),
        .FRAC_BITS (11),
        .IN_W      (21),
        .LEAK_SHIFT(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat)
`ifdef ACTIVATION_SATCNT_EN
        ,
        .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One isolated item: accept, empty after one edge, valid result after two.
    task automatic run_one(input string tag, input logic [1:0] mode, input logic [IN_W-1:0] data,
                           input logic [DATA_W-1:0] exp_data, input logic exp_sat);
        @(negedge clk);
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_out"}, {15'd0, out_sat, out_data}, {15'd0, exp_sat, exp_data});
    endtask

    logic [1:0]        bp_mode [5];
    logic [IN_W-1:0]   bp_data [5];
    logic [16:0]       bp_exp  [5];

    initial begin
        int idx, acc, out_idx, first_cyc, last_cyc;

        bp_mode[0] = 2'd2; bp_data[0] = 21'h000400; bp_exp[0] = {1'b0, 16'h0400};
        bp_mode[1] = 2'd0; bp_data[1] = 21'h1FF000; bp_exp[1] = {1'b0, 16'h0000};
        bp_mode[2] = 2'd1; bp_data[2] = 21'h1FC000; bp_exp[2] = {1'b0, 16'hF800};
        bp_mode[3] = 2'd3; bp_data[3] = 21'h1FFFFF; bp_exp[3] = {1'b1, 16'h0000};
        bp_mode[4] = 2'd2; bp_data[4] = 21'h0FFFFF; bp_exp[4] = {1'b1, 16'h7FFF};

        #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_sat", 32'(out_sat), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_one("relu_neg",   2'd0, 21'h1FF800, 16'h0000, 1'b0);
        run_one("relu_maxp",  2'd0, 21'h007FFF, 16'h7FFF, 1'b0);
        run_one("relu_ovf",   2'd0, 21'h008000, 16'h7FFF, 1'b1);
        run_one("leak_neg",   2'd1, 21'h1FF800, 16'hFF00, 1'b0);
        run_one("leak_clamp", 2'd1, 21'h100000, 16'h8000, 1'b1);
        run_one("leak_m1",    2'd1, 21'h1FFFFF, 16'hFFFF, 1'b0);
        run_one("id_maxp",    2'd2, 21'h007FFF, 16'h7FFF, 1'b0);
        run_one("id_neg_ovf", 2'd2, 21'h1F63C0, 16'h8000, 1'b1);
        run_one("clip_hi",    2'd3, 21'h001000, 16'h0800, 1'b1);
        run_one("clip_one",   2'd3, 21'h000800, 16'h0800, 1'b0);

        // Backpressure: out_ready low for the first 4 cycles, then streaming
        idx = 0; acc = 0; out_idx = 0; first_cyc = -1; last_cyc = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 4);
            #1;
            if (out_valid && out_ready) begin
                if (out_idx < 5)
                    check_eq($sformatf("bp_item%0d", out_idx), {15'd0, out_sat, out_data},
                             {15'd0, bp_exp[out_idx]});
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                out_idx++;
            end
            if (cyc == 2 || cyc == 3) begin
                check_eq("bp_hold_vld", 32'(out_valid), 32'd1);
                check_eq("bp_hold_data", {15'd0, out_sat, out_data}, {15'd0, bp_exp[0]});
            end
            if (idx < 5) begin
                in_valid = 1'b1;
                in_mode  = bp_mode[idx];
                in_data  = bp_data[idx];
                if (in_ready) begin
                    idx++;
                    if (cyc < 4) acc++;
                end
            end else begin
                in_valid = 1'b0;
            end
            if (cyc == 3) begin
                check_eq("bp_accepted", 32'(acc), 32'd2);
                check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            end
        end
        in_valid = 1'b0;
        check_eq("bp_count", 32'(out_idx), 32'd5);
        check_eq("bp_rate", 32'(last_cyc - first_cyc), 32'd4);

        // Reset with two items in flight
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd0;
        in_data   = 21'h008000;
        @(negedge clk);
        in_mode   = 2'd2;
        in_data   = 21'h1F63C0;
        @(negedge clk);
        in_valid  = 1'b0;
        #1;
        check_eq("pre_rst_out", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h7FFF});
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_data", 32'(out_data), 32'd0);
        check_eq("mid_rst_sat", 32'(out_sat), 32'd0);
`ifdef ACTIVATION_SATCNT_EN
        check_eq("mid_rst_satcnt", 32'(sat_count), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("post_rst_idle", 32'(out_valid), 32'd0);
        end

`ifdef ACTIVATION_SATCNT_EN
        run_one("cnt_s0", 2'd0, 21'h008000, 16'h7FFF, 1'b1);
        run_one("cnt_s1", 2'd2, 21'h1F63C0, 16'h8000, 1'b1);
        run_one("cnt_c0", 2'd2, 21'h007FFF, 16'h7FFF, 1'b0);
        run_one("cnt_s2", 2'd3, 21'h001000, 16'h0800, 1'b1);
        run_one("cnt_c1", 2'd3, 21'h000800, 16'h0800, 1'b0);
        @(negedge clk);
        check_eq("satcnt_3", 32'(sat_count), 32'd3);
        rst = 1'b1;
        #1;
        check_eq("satcnt_rst", 32'(sat_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
